// File: rtl/ssd_display_arbiter_pkg.sv
// Shared constants for the seven-segment display arbiter and its benches.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ssd_display_arbiter_pkg;

  // FSM encoding, kept as plain constants so older benches can compare raw bits
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  // Display geometry: eight 4-bit digits packed into one 32-bit word
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 8;
  localparam int WORD_W     = DIGIT_W * NUM_DIGITS;

  // Word driven when nothing is being shown
  localparam logic [WORD_W-1:0] BLANK_WORD = '0;

endpackage

// File: rtl/ssd_display_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched upward from the client after the last winner.
// Latency: grant is combinational from req; pointer moves on the edge that accepts.
// Backpressure: pointer only advances when the caller signals accept, so refused grants do not rotate.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_grant;

  // Search from last_grant+1, wrapping, and pick the first requester found
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Remember the winner; reset value N-1 makes client 0 the first candidate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDX_W'(N - 1);
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Shares the 8-digit display between NUM_REQ clients; each accepted word is shown for DWELL_CYCLES.
// Latency: accepted word appears on encoded one cycle after the accepting edge.
// Backpressure: req_ready only in IDLE or when the dwell has expired with hold low; clients keep valid/data until ready.
module ssd_display_arbiter
  import ssd_display_arbiter_pkg::*;
#(
  parameter int          NUM_REQ       = 4,
  parameter int          DWELL_CYCLES  = 100_000_000,
  parameter logic [31:0] IDLE_WORD     = BLANK_WORD,
  parameter bit          BLANK_ON_IDLE = 1'b0,
  parameter int          ID_W          = $clog2(NUM_REQ)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    hold,
  output logic [31:0]             encoded,
  output logic [ID_W-1:0]         active_id,
  output logic                    showing
);

  localparam int               CNT_W      = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  logic [0:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               window;
  logic               accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [31:0]        sel_word;

  // A new word may be taken when idle, or once the current dwell is used up and not paused
  assign window    = (state == ST_IDLE) || ((cnt == '0) && !hold);
  assign accept    = window && (|req_valid) && !Reset;
  assign req_ready = accept ? grant : '0;
  assign showing   = (state == ST_SHOW);

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .clk       (Clk),
    .rst       (Reset),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Pick the granted client's word out of the flat data bus
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_word = req_data[32*i +: 32];
    end
  end

  // FSM, dwell countdown and display registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      encoded   <= IDLE_WORD;
      active_id <= '0;
    end else if (accept) begin
      state     <= ST_SHOW;
      cnt       <= DWELL_LOAD;
      encoded   <= sel_word;
      active_id <= grant_idx;
    end else if ((state == ST_SHOW) && !hold) begin
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        // Dwell over and nobody waiting: drop back to idle
        state <= ST_IDLE;
        if (BLANK_ON_IDLE) encoded <= IDLE_WORD;
      end
    end
  end

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Bench for ssd_display_arbiter: directed scenarios plus random traffic against a behavioural model.
// Latency: model expects accepted words visible one cycle after the accepting edge.
// Backpressure: bench clients hold valid/data until accepted (random withdrawals also exercised).
module tb_ssd_display_arbiter;

  localparam int N     = 4;
  localparam int DWELL = 4;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [N-1:0] req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         hold;
  logic [31:0]  encoded;
  logic [1:0]   active_id;
  logic         showing;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: what is on the display, who owns it, how many unpaused cycles it has had
  bit          m_show;
  logic [31:0] m_enc;
  int          m_id;
  int          m_served;
  int          m_last;

  ssd_display_arbiter #(
    .NUM_REQ       (N),
    .DWELL_CYCLES  (DWELL),
    .IDLE_WORD     (32'h0000_0000),
    .BLANK_ON_IDLE (1'b1)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .encoded   (encoded),
    .active_id (active_id),
    .showing   (showing)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_show   = 1'b0;
    m_enc    = 32'h0;
    m_id     = 0;
    m_served = 0;
    m_last   = N - 1;
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks at negedge, returns granted index or -1
  task automatic step(input logic [N-1:0] v, input logic [32*N-1:0] d, input logic h, output int g);
    logic [N-1:0] exp_ready;
    bit           win;
    req_valid = v;
    req_data  = d;
    hold      = h;
    @(negedge Clk);
    g         = -1;
    exp_ready = '0;
    // A word must have been shown DWELL cycles (unpaused) before anyone else gets the display
    win = !m_show || (m_served >= DWELL - 1 && !h);
    if (win) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("encoded",   encoded,        m_enc);
    chk("showing",   32'(showing),   32'(m_show));
    if (m_show) chk("active_id", 32'(active_id), 32'(m_id));
    if (g >= 0) begin
      m_show   = 1'b1;
      m_enc    = d[32*g +: 32];
      m_id     = g;
      m_served = 0;
      m_last   = g;
    end else if (m_show && !h) begin
      if (m_served >= DWELL - 1) begin
        m_show = 1'b0;
        m_enc  = 32'h0;
      end else begin
        m_served++;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  logic [32*N-1:0] dat;
  logic [N-1:0]    pend;
  int              g;
  int              grants[$];
  int              gsteps[$];
  int              s0, s3;

  initial begin
    Reset     = 1'b1;
    req_valid = '1;
    req_data  = '0;
    hold      = 1'b0;
    model_reset();
    #2;
    // Reset values, and no ready while Reset is high even with all clients valid
    chk("rst_encoded", encoded, 32'h0);
    chk("rst_showing", 32'(showing), 32'h0);
    chk("rst_ready",   32'(req_ready), 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Async reset in the middle of a dwell
    dat = '0;
    dat[31:0] = 32'h0123_4567;
    step(4'b0001, dat, 1'b0, g);
    step(4'b0000, dat, 1'b0, g);
    chk("pre_rst_encoded", encoded, 32'h0123_4567);
    req_valid = 4'b1111;
    #2;
    Reset = 1'b1;
    #1;
    chk("async_encoded", encoded, 32'h0);
    chk("async_showing", 32'(showing), 32'h0);
    chk("async_ready",   32'(req_ready), 32'h0);
    model_reset();
    @(negedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Single client 2
    dat = '0;
    dat[64 +: 32] = 32'hDEAD_BEEF;
    step(4'b0100, dat, 1'b0, g);
    chk("t2_grant", 32'(g), 32'd2);
    chk("t2_active", 32'(active_id), 32'd2);
    for (int i = 0; i < DWELL; i++) step(4'b0000, dat, 1'b0, g);
    chk("t2_blank_enc", encoded, 32'h0);
    chk("t2_blank_show", 32'(showing), 32'h0);

    // Clients 0,1,3 from a fresh reset: order 0,1,3, DWELL apart
    Reset = 1'b1;
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < N; i++) dat[32*i +: 32] = 32'hA000_0000 + 32'(i);
    pend = 4'b1011;
    for (int s = 0; s < 16; s++) begin
      step(pend, dat, 1'b0, g);
      if (g >= 0) begin
        pend[g] = 1'b0;
        grants.push_back(g);
        gsteps.push_back(s);
      end
    end
    chk("t3_count", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      chk("t3_first",  32'(grants[0]), 32'd0);
      chk("t3_second", 32'(grants[1]), 32'd1);
      chk("t3_third",  32'(grants[2]), 32'd3);
      chk("t3_gap1",   32'(gsteps[1] - gsteps[0]), 32'(DWELL));
      chk("t3_gap2",   32'(gsteps[2] - gsteps[1]), 32'(DWELL));
    end

    // Client 1 always valid, client 0 re-requests after each grant: must alternate
    grants.delete();
    pend = 4'b0011;
    for (int s = 0; s < 40 && grants.size() < 6; s++) begin
      step(pend, dat, 1'b0, g);
      pend = 4'b0011;
      if (g >= 0) begin
        grants.push_back(g);
        if (g == 0) pend[0] = 1'b0;
      end
    end
    chk("t4_count", 32'(grants.size()), 32'd6);
    foreach (grants[k]) chk("t4_alternate", 32'(grants[k]), 32'(k % 2));

    // Hold for 10 cycles mid-dwell with client 3 waiting: word shown DWELL+10 cycles
    for (int i = 0; i < DWELL + 2; i++) step(4'b0000, dat, 1'b0, g);
    s0 = 0;
    s3 = -1;
    step(4'b0001, dat, 1'b0, g);
    chk("t5_first", 32'(g), 32'd0);
    for (int s = 1; s < 40 && s3 < 0; s++) begin
      step(4'b1000, dat, (s >= 2 && s <= 11), g);
      if (g == 3) s3 = s;
    end
    chk("t5_dwell", 32'(s3 - s0), 32'(DWELL + 10));

    // Random traffic: clients post, sometimes withdraw, hold toggles occasionally
    pend = '0;
    for (int s = 0; s < 600; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          dat[32*i +: 32] = $urandom;
        end else if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step(pend, dat, ($urandom_range(0, 7) == 0), g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
